// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: single-clock UART transmitter with a one-word holding buffer,
// valid/ready input handshake, per-frame parity mode and stop-bit count.
// The baud rate comes from an internal clocks-per-bit divider on sysclk_in.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 sysclk_in,
  input  logic                 nrst_in,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_valid_in,
  output logic                 tx_ready_out,
  input  logic [1:0]           parity_mode_in,
  input  logic                 two_stop_in,
  output logic                 tx_serial_out,
  output logic                 tx_busy_out,
  output logic                 tx_done_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Holding buffer
  logic                 full_reg;
  logic [DATA_BITS-1:0] buf_data_reg;
  logic [1:0]           buf_mode_reg;
  logic                 buf_two_reg;

  // Frame in flight
  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [IW-1:0]        idx_reg, idx_next;
  logic                 stop_reg, stop_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_en_reg, par_en_next;
  logic                 par_odd_reg, par_odd_next;
  logic                 two_reg, two_next;
  logic                 serial_reg, serial_next;

  logic accept;
  logic load;
  logic done;
  logic bit_end;

  assign accept  = tx_valid_in & ~full_reg;
  assign bit_end = (cnt_reg == BIT_LAST);

  assign tx_ready_out  = ~full_reg;
  assign tx_busy_out   = (state_reg != S_IDLE);
  assign tx_done_out   = done;
  assign tx_serial_out = serial_reg;

  // Capture word and its frame config at the handshake; free the slot on load.
  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      full_reg     <= 1'b0;
      buf_data_reg <= '0;
      buf_mode_reg <= 2'b00;
      buf_two_reg  <= 1'b0;
    end else if (accept) begin
      full_reg     <= 1'b1;
      buf_data_reg <= tx_data_in;
      buf_mode_reg <= parity_mode_in;
      buf_two_reg  <= two_stop_in;
    end else if (load) begin
      full_reg     <= 1'b0;
    end
  end

  // Next-state, bit timer, data index and stop-bit sequencing.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    stop_next  = stop_reg;
    load       = 1'b0;
    done       = 1'b0;

    if (state_reg == S_IDLE) begin
      cnt_next = '0;
    end else if (bit_end) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (full_reg) begin
          load       = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          idx_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_reg == IDX_LAST) begin
            state_next = par_en_reg ? S_PARITY : S_STOP;
            stop_next  = 1'b0;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          stop_next  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (two_reg && !stop_reg) begin
            stop_next = 1'b1;
          end else begin
            // Final stop bit ends: pulse done and chain straight into the
            // next frame when a word is waiting, so no idle gap appears.
            done = 1'b1;
            if (full_reg) begin
              load       = 1'b1;
              state_next = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Frame config and data move from the buffer only when a frame starts, so
  // later changes on the inputs cannot reach a frame already in flight.
  always_comb begin
    shift_next   = shift_reg;
    par_en_next  = par_en_reg;
    par_odd_next = par_odd_reg;
    two_next     = two_reg;
    if (load) begin
      shift_next   = buf_data_reg;
      par_en_next  = (buf_mode_reg == 2'b01) || (buf_mode_reg == 2'b10);
      par_odd_next = buf_mode_reg[1];
      two_next     = buf_two_reg;
    end
  end

  // Line value is derived from the next state so the registered line changes
  // on the same edge as the state register.
  always_comb begin
    serial_next = 1'b1;
    case (state_next)
      S_START:  serial_next = 1'b0;
      S_DATA:   serial_next = shift_next[idx_next];
      S_PARITY: serial_next = (^shift_next) ^ par_odd_next;
      default:  serial_next = 1'b1;
    endcase
  end

  // State, timer and frame registers; reset forces the line high at once.
  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      stop_reg    <= 1'b0;
      shift_reg   <= '0;
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      two_reg     <= 1'b0;
      serial_reg  <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      stop_reg    <= stop_next;
      shift_reg   <= shift_next;
      par_en_reg  <= par_en_next;
      par_odd_reg <= par_odd_next;
      two_reg     <= two_next;
      serial_reg  <= serial_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for uart_tx_cfg with
// CLKS_PER_BIT=4, DATA_BITS=8. Expected frames are hand-built bit vectors
// (bit 0 = first bit on the line).
module tb_uart_tx_cfg;
  localparam int CPB = 4;

  logic       clk;
  logic       nrst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int errors = 0;
  int checks = 0;

  uart_tx_cfg #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .sysclk_in     (clk),
    .nrst_in       (nrst),
    .tx_data_in    (tx_data),
    .tx_valid_in   (tx_valid),
    .tx_ready_out  (tx_ready),
    .parity_mode_in(parity_mode),
    .two_stop_in   (two_stop),
    .tx_serial_out (tx_serial),
    .tx_busy_out   (tx_busy),
    .tx_done_out   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe a run of frames starting on the cycle after acceptance (caller is
  // just past the accepting edge). rdy2_exp is ready expected at cycle 2.
  task automatic observe(input string tag, input logic [31:0] exp_bits,
                         input int nbits, input int done1, input int done2,
                         input int rdy2_exp);
    int len;
    int bad_line;
    int busy_low;
    int dcount;
    int dpos1;
    int dpos2;
    len = nbits * CPB;
    bad_line = 0;
    busy_low = 0;
    dcount = 0;
    dpos1 = 0;
    dpos2 = 0;
    for (int k = 1; k <= len; k++) begin
      tick();
      if (tx_serial !== exp_bits[5'((k - 1) / CPB)]) bad_line++;
      if (tx_busy !== 1'b1) busy_low++;
      if (tx_done === 1'b1) begin
        dcount++;
        if (dcount == 1) dpos1 = k;
        if (dcount == 2) dpos2 = k;
      end
      if (k == 1) check_val({tag, "_ready_c1"}, int'(tx_ready), 1);
      if (k == 2) begin
        check_val({tag, "_ready_c2"}, int'(tx_ready), rdy2_exp);
        tx_valid = 1'b0;
      end
      if (k == 10) begin
        // Config and data changes mid-frame must not reach the frame.
        parity_mode = ~parity_mode;
        two_stop    = ~two_stop;
        tx_data     = ~tx_data;
      end
    end
    check_val({tag, "_bad_line_cycles"}, bad_line, 0);
    check_val({tag, "_busy_low_cycles"}, busy_low, 0);
    check_val({tag, "_done_count"}, dcount, (done2 != 0) ? 2 : 1);
    check_val({tag, "_done_pos1"}, dpos1, done1);
    if (done2 != 0) check_val({tag, "_done_pos2"}, dpos2, done2);
    tick();
    check_val({tag, "_busy_after"}, int'(tx_busy), 0);
    check_val({tag, "_line_after"}, int'(tx_serial), 1);
  endtask

  // Offer one word from idle and check the full frame.
  task automatic send(input string tag, input logic [7:0] d, input logic [1:0] m,
                      input logic t, input logic [31:0] exp_bits, input int nbits);
    check_val({tag, "_ready_idle"}, int'(tx_ready), 1);
    tx_data     = d;
    parity_mode = m;
    two_stop    = t;
    tx_valid    = 1'b1;
    tick();
    check_val({tag, "_ready_e0"}, int'(tx_ready), 0);
    check_val({tag, "_line_e0"}, int'(tx_serial), 1);
    tx_valid = 1'b0;
    observe(tag, exp_bits, nbits, nbits * CPB, 0, 1);
    tick();
  endtask

  initial begin
    int bad;
    nrst        = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;

    // Reset state
    #12;
    check_val("rst_line", int'(tx_serial), 1);
    check_val("rst_ready", int'(tx_ready), 1);
    check_val("rst_busy", int'(tx_busy), 0);
    check_val("rst_done", int'(tx_done), 0);
    tick();
    nrst = 1'b1;
    tick();
    tick();

    // Basic frame 0xA5: 0,1,0,1,0,0,1,0,1,1
    send("basic_a5", 8'hA5, 2'b00, 1'b0, 32'({1'b1, 8'hA5, 1'b0}), 10);
    // 0x07 even parity -> parity bit 1; odd -> 0
    send("even_07", 8'h07, 2'b01, 1'b0, 32'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
    send("odd_07", 8'h07, 2'b10, 1'b0, 32'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
    // Reserved mode 11 behaves as no parity
    send("mode3_3c", 8'h3C, 2'b11, 1'b0, 32'({1'b1, 8'h3C, 1'b0}), 10);
    // Two stop bits: low 36 cycles, high 8
    send("two_stop_00", 8'h00, 2'b00, 1'b1, 32'({2'b11, 8'h00, 1'b0}), 11);

    // Back-to-back: 0x11 then 0x22 held on valid
    tx_data     = 8'h11;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    tx_valid    = 1'b1;
    tick();
    check_val("b2b_ready_e0", int'(tx_ready), 0);
    tx_data = 8'h22;
    observe("b2b", 32'({1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}), 20, 40, 80, 0);
    tick();

    // Reset in the middle of a frame
    tx_data     = 8'h00;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    tx_valid    = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k <= 13; k++) tick();
    check_val("pre_rst_line", int'(tx_serial), 0);
    check_val("pre_rst_busy", int'(tx_busy), 1);
    nrst = 1'b0;
    #1;
    check_val("midrst_line", int'(tx_serial), 1);
    check_val("midrst_ready", int'(tx_ready), 1);
    check_val("midrst_busy", int'(tx_busy), 0);
    check_val("midrst_done", int'(tx_done), 0);
    tick();
    tick();
    nrst = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    check_val("post_rst_idle_bad_cycles", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, single-clock UART transmitter with a one-word holding buffer and a valid/ready input handshake. The baud rate is derived internally from `sysclk_in` by a clocks-per-bit divider, so no separate baud clock is needed. Parity mode and stop-bit count are captured per frame. The block sits between a byte-stream producer (CPU bridge, FIFO, packetiser) and the `tx` pin, and supports back-to-back frames with no idle gap.

## Interface

**Parameters**

- `CLKS_PER_BIT`, default 16: sysclk cycles per serial bit; legal range ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.

**Ports**

- `sysclk_in`  in  1: system clock, rising edge.
- `nrst_in`  in  1: reset, asynchronous, active-low.
- `tx_data_in`  in  DATA_BITS: word to send.
- `tx_valid_in`  in  1: producer offers `tx_data_in`.
- `tx_ready_out`  out  1: holding buffer empty; a word is accepted on an edge where `tx_valid_in & tx_ready_out`.
- `parity_mode_in`  in  2: 00 none, 01 even, 10 odd, 11 none (reserved). Captured with the data word.
- `two_stop_in`  in  1: 0 selects one stop bit, 1 selects two. Captured with the data word.
- `tx_serial_out`  out  1: serial line, idle high.
- `tx_busy_out`  out  1: high while the FSM is not IDLE.
- `tx_done_out`  out  1: one-cycle pulse at the end of the final stop bit.

## Operation

- **Holding buffer:** one entry of {data, parity_mode, two_stop} plus a `full` flag.
  - `tx_ready_out = ~full`.
  - A handshake sets `full`; loading the shifter clears it.
  - Accept and load never coincide, because load requires `full`, which forces ready low.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Bit timer:** `bit_cnt`, width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - "Bit end" means `bit_cnt == CLKS_PER_BIT-1`; the counter then wraps to 0.
- **Transitions:**
  - IDLE → START when `full`: load shifter and frame config, clear `full`, reset `bit_cnt`.
  - START → DATA at bit end; data index set to 0.
  - DATA: the index increments at each bit end. After bit DATA_BITS-1, go to PARITY if the captured mode is 01/10, otherwise to STOP.
  - PARITY → STOP at bit end.
  - STOP lasts 1 or 2 bit periods, per the captured `two_stop`.
  - At the end of the final stop bit, pulse `tx_done_out`. Then go to START if `full` (load as from IDLE, no idle gap), otherwise to IDLE.
- **Line value:**
  - IDLE and STOP: 1.
  - START: 0.
  - DATA: `shift[idx]`, LSB first.
  - PARITY: XOR-reduce of the data word for even; its inverse for odd.
- The line value is registered and follows the state register with no additional delay.
- Config inputs are sampled only at the handshake. Changes at any other time have no effect on buffered or in-flight frames.
- `tx_valid_in` while `tx_ready_out=0` is ignored. The producer must hold its data until the handshake.

## Timing

- **Reset values:**
  - `tx_serial_out=1`, `tx_busy_out=0`, `tx_done_out=0`, `tx_ready_out=1`.
  - FSM in IDLE, `full=0`, counters 0.
- **Reset mid-frame:** the line returns high immediately (asynchronously), and the buffered word is discarded. After release, the block is idle and no partial frame resumes.
- **Latency:** handshake on edge E0, START entered on E1. `tx_serial_out` falls after E1, i.e. 1 cycle after acceptance when idle.
- **Frame length:** (1 + DATA_BITS + P + S) × CLKS_PER_BIT cycles, where P ∈ {0,1} and S ∈ {1,2}. Every bit is exactly CLKS_PER_BIT cycles.
- **Done and busy:** `tx_done_out` is high for exactly one cycle, on the last cycle of the final stop bit. `tx_busy_out` drops on the following edge only if no word is buffered.
- **Ready after idle acceptance:** `tx_ready_out` is low for exactly one cycle (E0 to E1), then high again. A second word can therefore be buffered during the first frame.
- **Back-to-back:** the next start bit begins on the cycle immediately after the final stop bit, so there is no gap between frames.

## Test plan

- **Basic frame:** CLKS_PER_BIT=4, DATA_BITS=8, send 0xA5, parity none, one stop. Line must read 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles (40 cycles total). `tx_done_out` pulses once at cycle 40; busy is high for cycles 1..40.
- **Parity:** 0x07 with even parity gives parity bit 1; 0x07 with odd parity gives parity bit 0. Frame length is 44 cycles. Parity mode 11 produces a 40-cycle frame with no parity bit.
- **Two stop bits:** 0x00 with `two_stop_in=1`. Line is low for 36 cycles, then high for 8; done pulses at cycle 44.
- **Back-to-back:** offer 0x11, then hold `tx_valid_in` with 0x22.
  - 0x22 is accepted the cycle after ready reasserts.
  - The second start bit follows the first stop bit with no high gap.
  - Busy never drops between frames; there are two done pulses 40 cycles apart.
- **Config isolation and reset:**
  - Change `parity_mode_in` mid-frame: the frame is unaffected.
  - Assert `nrst_in` at bit 3: the line goes high the same cycle, and ready, busy and done take their reset values.
  - After release, with no stimulus, the line stays high.
